// File: rtl/fetch_queue.sv
// Purpose: fetch-entry FIFO between the I$ fetch path and ID; squashed by flush, sealed by a faulting fetch.
// Latency: an accepted entry is presented to ID on the following cycle; output is purely registered.
// Backpressure: in_ready_o depends only on registered state (not full, no pending fault); ack while full does not admit a push.
package fetch_queue_pkg;

    typedef struct packed {
        logic       valid;
        logic [3:0] cause;
    } ex_t;

    typedef struct packed {
        logic valid;
        logic taken;
    } branch_predict_t;

    typedef struct packed {
        logic [31:0]     address;
        logic [31:0]     instruction;
        branch_predict_t branch_predict;
        ex_t             ex;
    } fetch_entry_t;

endpackage

module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    input  fetch_entry_t             in_entry_i,
    output logic                     in_ready_o,
    output fetch_entry_t             fetch_entry_o,
    output logic                     fetch_entry_valid_o,
    input  logic                     fetch_ack_i,
    output logic [$clog2(DEPTH):0]   usage_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   rptr_q;
    logic [PW-1:0]   wptr_q;
    logic [PW:0]     count_q;
    logic            ex_stall_q;
    logic            push;
    logic            pop;

    // Ready is taken from registered state only, so a pop cannot open a full queue in the same cycle.
    assign in_ready_o          = (count_q != FULL) && !ex_stall_q;
    assign fetch_entry_valid_o = (count_q != '0);
    assign fetch_entry_o       = mem[rptr_q];
    assign usage_o             = count_q;

    // Flush overrides both handshakes: nothing is stored or consumed in a flush cycle.
    assign push = in_valid_i && in_ready_o && !flush_i;
    assign pop  = fetch_ack_i && fetch_entry_valid_o && !flush_i;

    // Entry storage; contents need no reset because valid is derived from the count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wptr_q] <= in_entry_i;
        end
    end

    // Pointers, occupancy and the fault seal.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q     <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
            ex_stall_q <= 1'b0;
        end else if (flush_i) begin
            rptr_q     <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
            ex_stall_q <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
            // A faulting fetch blocks everything younger until the pipeline is flushed.
            if (push && in_entry_i.ex.valid) begin
                ex_stall_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue (DEPTH=4): scoreboard of accepted entries, compared as ID acknowledges them.
// Inputs change 1 time unit after the rising edge; outputs are sampled there as well.
// Model tracks occupancy and fault seal independently of the DUT.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;

    logic          clk_i;
    logic          rst_ni;
    logic          flush_i;
    logic          in_valid_i;
    fetch_entry_t  in_entry_i;
    logic          in_ready_o;
    fetch_entry_t  fetch_entry_o;
    logic          fetch_entry_valid_o;
    logic          fetch_ack_i;
    logic [2:0]    usage_o;

    int            vectors;
    int            miscompares;
    fetch_entry_t  sb [$];
    bit            m_stall;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .flush_i             (flush_i),
        .in_valid_i          (in_valid_i),
        .in_entry_i          (in_entry_i),
        .in_ready_o          (in_ready_o),
        .fetch_entry_o       (fetch_entry_o),
        .fetch_entry_valid_o (fetch_entry_valid_o),
        .fetch_ack_i         (fetch_ack_i),
        .usage_o             (usage_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic fetch_entry_t mk(input int n, input bit exv);
        fetch_entry_t e;
        e.address              = 32'h0000_1000 + 32'(n) * 4;
        e.instruction          = 32'hA500_0000 + 32'(n);
        e.branch_predict.valid = n[0];
        e.branch_predict.taken = n[1];
        e.ex.valid             = exv;
        e.ex.cause             = exv ? 4'd1 : 4'd0;
        return e;
    endfunction

    // Advance one clock, updating the reference model from the inputs held this cycle.
    task automatic tick();
        bit po, pu;
        po = fetch_ack_i && (sb.size() != 0);
        pu = in_valid_i && (sb.size() != DEPTH) && !m_stall;
        if (flush_i) begin
            sb.delete();
            m_stall = 1'b0;
        end else begin
            if (po) void'(sb.pop_front());
            if (pu) begin
                sb.push_back(in_entry_i);
                if (in_entry_i.ex.valid) m_stall = 1'b1;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        in_valid_i  = 1'b0;
        fetch_ack_i = 1'b0;
        flush_i     = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        in_entry_i = mk(0, 1'b0);
        rst_ni = 1'b0;
        #12;
        vectors++; if (fetch_entry_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", fetch_entry_valid_o); end
        vectors++; if (in_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", in_ready_o); end
        vectors++; if (usage_o !== 3'd0) begin miscompares++; $display("FAIL reset_usage got %0d want 0", usage_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 4; i++) begin
            in_valid_i = 1'b1; in_entry_i = mk(10 + i, 1'b0);
            tick();
        end
        idle();
        vectors++; if (in_ready_o !== 1'b0) begin miscompares++; $display("FAIL fill_ready got %b want 0", in_ready_o); end
        vectors++; if (usage_o !== 3'd4) begin miscompares++; $display("FAIL fill_usage got %0d want 4", usage_o); end
        in_valid_i = 1'b1; in_entry_i = mk(14, 1'b0);
        tick();
        idle();
        vectors++; if (usage_o !== 3'd4) begin miscompares++; $display("FAIL fill_fifth_usage got %0d want 4", usage_o); end
        for (int i = 0; i < 4; i++) begin
            vectors++; if (fetch_entry_valid_o !== 1'b1 || fetch_entry_o !== mk(10 + i, 1'b0)) begin
                miscompares++; $display("FAIL drain_%0d got v=%b %h want v=1 %h", i, fetch_entry_valid_o, fetch_entry_o, mk(10 + i, 1'b0));
            end
            fetch_ack_i = 1'b1;
            tick();
        end
        idle();
        vectors++; if (fetch_entry_valid_o !== 1'b0) begin miscompares++; $display("FAIL drain_empty got %b want 0", fetch_entry_valid_o); end
    endtask

    task automatic test_wrap();
        for (int i = 1; i <= 3; i++) begin
            in_valid_i = 1'b1; in_entry_i = mk(i, 1'b0); tick();
        end
        idle();
        for (int i = 0; i < 2; i++) begin
            fetch_ack_i = 1'b1; tick();
        end
        idle();
        for (int i = 4; i <= 6; i++) begin
            in_valid_i = 1'b1; in_entry_i = mk(i, 1'b0); tick();
        end
        idle();
        vectors++; if (usage_o !== 3'd4) begin miscompares++; $display("FAIL wrap_usage got %0d want 4", usage_o); end
        for (int i = 3; i <= 6; i++) begin
            vectors++; if (fetch_entry_o !== mk(i, 1'b0) || fetch_entry_o !== sb[0]) begin
                miscompares++; $display("FAIL wrap_order_%0d got %h want %h", i, fetch_entry_o, mk(i, 1'b0));
            end
            fetch_ack_i = 1'b1; tick();
        end
        idle();
        vectors++; if (fetch_entry_valid_o !== 1'b0 || usage_o !== 3'd0) begin miscompares++; $display("FAIL wrap_empty got v=%b u=%0d want v=0 u=0", fetch_entry_valid_o, usage_o); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            in_valid_i = 1'b1; in_entry_i = mk(20 + i, 1'b0); tick();
        end
        for (int i = 0; i < 10; i++) begin
            vectors++; if (usage_o !== 3'd2 || fetch_entry_o !== sb[0]) begin
                miscompares++; $display("FAIL b2b_%0d got u=%0d %h want u=2 %h", i, usage_o, fetch_entry_o, sb[0]);
            end
            in_valid_i = 1'b1; in_entry_i = mk(22 + i, 1'b0); fetch_ack_i = 1'b1;
            tick();
        end
        fetch_ack_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid_i = 1'b1; in_entry_i = mk(40 + i, 1'b0); tick();
        end
        vectors++; if (usage_o !== 3'd4 || in_ready_o !== 1'b0) begin miscompares++; $display("FAIL b2b_full got u=%0d r=%b want u=4 r=0", usage_o, in_ready_o); end
        in_valid_i = 1'b1; in_entry_i = mk(50, 1'b0); fetch_ack_i = 1'b1;
        tick();
        idle();
        vectors++; if (usage_o !== 3'd3 || in_ready_o !== 1'b1) begin miscompares++; $display("FAIL b2b_full_pop got u=%0d r=%b want u=3 r=1", usage_o, in_ready_o); end
        while (sb.size() != 0) begin
            vectors++; if (fetch_entry_o !== sb[0]) begin miscompares++; $display("FAIL b2b_drain got %h want %h", fetch_entry_o, sb[0]); end
            fetch_ack_i = 1'b1; tick();
        end
        idle();
        vectors++; if (fetch_entry_valid_o !== 1'b0) begin miscompares++; $display("FAIL b2b_empty got %b want 0", fetch_entry_valid_o); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1; in_entry_i = mk(60 + i, 1'b0); tick();
        end
        vectors++; if (usage_o !== 3'd3) begin miscompares++; $display("FAIL flush_pre_usage got %0d want 3", usage_o); end
        flush_i = 1'b1; fetch_ack_i = 1'b1; in_valid_i = 1'b1; in_entry_i = mk(63, 1'b0);
        tick();
        idle();
        vectors++; if (fetch_entry_valid_o !== 1'b0 || usage_o !== 3'd0 || in_ready_o !== 1'b1) begin
            miscompares++; $display("FAIL flush_state got v=%b u=%0d r=%b want v=0 u=0 r=1", fetch_entry_valid_o, usage_o, in_ready_o);
        end
        in_valid_i = 1'b1; in_entry_i = mk(64, 1'b0); tick();
        idle();
        vectors++; if (fetch_entry_o !== mk(64, 1'b0) || usage_o !== 3'd1) begin
            miscompares++; $display("FAIL flush_next got %h u=%0d want %h u=1", fetch_entry_o, usage_o, mk(64, 1'b0));
        end
        fetch_ack_i = 1'b1; tick();
        idle();
    endtask

    task automatic test_exception();
        in_valid_i = 1'b1; in_entry_i = mk(70, 1'b1); tick();
        for (int i = 0; i < 2; i++) begin
            vectors++; if (in_ready_o !== 1'b0) begin miscompares++; $display("FAIL ex_refuse_%0d ready got %b want 0", i, in_ready_o); end
            in_valid_i = 1'b1; in_entry_i = mk(71 + i, 1'b0); tick();
        end
        idle();
        vectors++; if (usage_o !== 3'd1 || fetch_entry_o !== mk(70, 1'b1)) begin
            miscompares++; $display("FAIL ex_head got u=%0d %h want u=1 %h", usage_o, fetch_entry_o, mk(70, 1'b1));
        end
        fetch_ack_i = 1'b1; tick();
        idle();
        vectors++; if (fetch_entry_valid_o !== 1'b0 || in_ready_o !== 1'b0) begin
            miscompares++; $display("FAIL ex_sealed got v=%b r=%b want v=0 r=0", fetch_entry_valid_o, in_ready_o);
        end
        flush_i = 1'b1; tick();
        idle();
        vectors++; if (in_ready_o !== 1'b1) begin miscompares++; $display("FAIL ex_unseal ready got %b want 1", in_ready_o); end
        in_valid_i = 1'b1; in_entry_i = mk(75, 1'b0); tick();
        idle();
        vectors++; if (usage_o !== 3'd1 || fetch_entry_o !== mk(75, 1'b0)) begin
            miscompares++; $display("FAIL ex_after_w got u=%0d %h want u=1 %h", usage_o, fetch_entry_o, mk(75, 1'b0));
        end
        fetch_ack_i = 1'b1; tick();
        idle();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            in_valid_i = 1'b1; in_entry_i = mk(80 + i, 1'b0); tick();
        end
        idle();
        vectors++; if (usage_o !== 3'd2) begin miscompares++; $display("FAIL rst_mid_pre usage got %0d want 2", usage_o); end
        #2;
        rst_ni = 1'b0;
        #1;
        vectors++; if (fetch_entry_valid_o !== 1'b0 || usage_o !== 3'd0 || in_ready_o !== 1'b1) begin
            miscompares++; $display("FAIL rst_mid got v=%b u=%0d r=%b want v=0 u=0 r=1", fetch_entry_valid_o, usage_o, in_ready_o);
        end
        sb.delete();
        m_stall = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b1; in_entry_i = mk(90, 1'b0); tick();
        idle();
        vectors++; if (usage_o !== 3'd1 || fetch_entry_o !== mk(90, 1'b0)) begin
            miscompares++; $display("FAIL rst_mid_after got u=%0d %h want u=1 %h", usage_o, fetch_entry_o, mk(90, 1'b0));
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_stall     = 1'b0;
        test_reset();
        test_fill_drain();
        test_wrap();
        test_back_to_back();
        test_flush();
        test_exception();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
